// File: rtl/quad_decoder_ud.sv
// Quadrature decoder: synchroniser, per-channel glitch filter, Gray-code phase decode to Up/Dw/err strobes.
// Define QDEC_X4_EN for a strobe on every legal step; undefined gives one strobe per encoder cycle (into phase 00).
module quad_decoder_ud #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CNT    = 8,
    parameter int ERRW        = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            qa,
    input  logic            qb,
    input  logic            clr_err,
    output logic            Up,
    output logic            Dw,
    output logic            dir,
    output logic            err,
    output logic [ERRW-1:0] err_cnt
);

    localparam int FCW = (FILT_CNT < 1) ? 1 : $clog2(FILT_CNT + 1);
    localparam int ICW = $clog2(SYNC_STAGES + 1);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [ICW-1:0]         r_init_cnt;
    logic [SYNC_STAGES-1:0] r_sync_a;
    logic [SYNC_STAGES-1:0] r_sync_b;
    logic [1:0]             w_s;
    logic [1:0]             w_ld;
    logic [1:0]             w_p;
    logic [1:0]             r_p_prev;
    logic                   w_init_last;
    logic                   w_run;
    logic                   w_fwd;
    logic                   w_bwd;
    logic                   w_up_nxt;
    logic                   w_dw_nxt;
    logic                   w_err_nxt;
    logic                   r_up;
    logic                   r_dw;
    logic                   r_err;
    logic                   r_dir;
    logic [ERRW-1:0]        r_err_cnt;

    assign w_s         = {r_sync_a[SYNC_STAGES-1], r_sync_b[SYNC_STAGES-1]};
    // Value the last sync stage takes on this edge, so the seeded phase matches the synced one.
    assign w_ld        = {r_sync_a[SYNC_STAGES-2], r_sync_b[SYNC_STAGES-2]};
    assign w_init_last = (r_state == S_INIT) && (r_init_cnt == ICW'(SYNC_STAGES - 1));
    assign w_run       = (r_state == S_RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_INIT;
            r_init_cnt <= '0;
            r_sync_a   <= '0;
            r_sync_b   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_sync_a <= {r_sync_a[SYNC_STAGES-2:0], qa};
            r_sync_b <= {r_sync_b[SYNC_STAGES-2:0], qb};
            if (r_state == S_INIT)
                r_init_cnt <= r_init_cnt + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_INIT:  if (w_init_last) w_state_nxt = S_RUN;
            S_RUN:   w_state_nxt = S_RUN;
            default: w_state_nxt = S_INIT;
        endcase
    end

    generate
        if (FILT_CNT == 0) begin : g_nofilt
            assign w_p = w_s;
        end else begin : g_filt
            logic [1:0]     r_f;
            logic [FCW-1:0] r_fc [2];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_f <= '0;
                    for (int i = 0; i < 2; i++) r_fc[i] <= '0;
                end else if (w_init_last) begin
                    r_f <= w_ld;
                    for (int i = 0; i < 2; i++) r_fc[i] <= '0;
                end else if (w_run) begin
                    for (int i = 0; i < 2; i++) begin
                        if (w_s[i] == r_f[i]) begin
                            r_fc[i] <= '0;
                        end else if (r_fc[i] == FCW'(FILT_CNT - 1)) begin
                            r_f[i]  <= w_s[i];
                            r_fc[i] <= '0;
                        end else begin
                            r_fc[i] <= r_fc[i] + 1'b1;
                        end
                    end
                end
            end

            assign w_p = r_f;
        end
    endgenerate

    always_comb begin
        w_fwd = 1'b0;
        w_bwd = 1'b0;
        case (r_p_prev)
            2'b00: begin w_fwd = (w_p == 2'b10); w_bwd = (w_p == 2'b01); end
            2'b10: begin w_fwd = (w_p == 2'b11); w_bwd = (w_p == 2'b00); end
            2'b11: begin w_fwd = (w_p == 2'b01); w_bwd = (w_p == 2'b10); end
            default: begin w_fwd = (w_p == 2'b00); w_bwd = (w_p == 2'b11); end
        endcase
    end

    assign w_err_nxt = w_run && ((w_p ^ r_p_prev) == 2'b11);
`ifdef QDEC_X4_EN
    assign w_up_nxt  = w_run && w_fwd;
    assign w_dw_nxt  = w_run && w_bwd;
`else
    assign w_up_nxt  = w_run && w_fwd && (w_p == 2'b00);
    assign w_dw_nxt  = w_run && w_bwd && (w_p == 2'b00);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_up      <= 1'b0;
            r_dw      <= 1'b0;
            r_err     <= 1'b0;
            r_dir     <= 1'b0;
            r_p_prev  <= '0;
            r_err_cnt <= '0;
        end else begin
            r_up     <= w_up_nxt;
            r_dw     <= w_dw_nxt;
            r_err    <= w_err_nxt;
            r_p_prev <= w_init_last ? w_ld : w_p;
            // Direction follows every legal step, including ones the x1 build does not strobe.
            if (w_run && w_fwd)
                r_dir <= 1'b1;
            else if (w_run && w_bwd)
                r_dir <= 1'b0;
            if (clr_err)
                r_err_cnt <= '0;
            else if (r_err && (r_err_cnt != {ERRW{1'b1}}))
                r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign Up      = r_up;
    assign Dw      = r_dw;
    assign err     = r_err;
    assign dir     = r_dir;
    assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_quad_decoder_ud.sv
// Scoreboard bench for quad_decoder_ud: directed phase sequences push expected strobes, a monitor pops them.
`timescale 1ns/1ps
module tb_quad_decoder_ud;

    localparam int S   = 2;
    localparam int F   = 8;
    localparam int EW  = 8;
    localparam int LAT = S + F + 1;
`ifdef QDEC_X4_EN
    localparam int X4 = 1;
`else
    localparam int X4 = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          qa = 1'b1;
    logic          qb = 1'b1;
    logic          clr_err = 1'b0;
    logic          Up, Dw, dir, err;
    logic [EW-1:0] err_cnt;

    quad_decoder_ud #(.SYNC_STAGES(S), .FILT_CNT(F), .ERRW(EW)) dut (
        .clk(clk), .rst(rst), .qa(qa), .qb(qb), .clr_err(clr_err),
        .Up(Up), .Dw(Dw), .dir(dir), .err(err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int q_kind[$];
    int q_cyc[$];
    int n_up = 0, n_dw = 0, n_err = 0;
    int mk, msum;
    logic [1:0] m_p;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // 0 none, 1 Up, 2 Dw, 3 err
    function automatic int predict(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] nf;
        logic       fwd;
        case (a)
            2'b00:   nf = 2'b10;
            2'b10:   nf = 2'b11;
            2'b11:   nf = 2'b01;
            default: nf = 2'b00;
        endcase
        if (a == b) return 0;
        if ((a ^ b) == 2'b11) return 3;
        fwd = (b == nf);
        if (X4 == 0 && b != 2'b00) return 0;
        return fwd ? 1 : 2;
    endfunction

    task automatic step(input logic [1:0] p, input int hold);
        int k;
        @(posedge clk); #1;
        {qa, qb} = p;
        k = predict(m_p, p);
        if (k != 0) begin
            q_kind.push_back(k);
            q_cyc.push_back(cyc + LAT);
        end
        m_p = p;
        repeat (hold - 1) @(posedge clk);
    endtask

    always @(negedge clk) begin
        if (!rst && (Up || Dw || err)) begin
            mk   = Up ? 1 : (Dw ? 2 : 3);
            msum = int'(Up) + int'(Dw) + int'(err);
            if (Up)  n_up++;
            if (Dw)  n_dw++;
            if (err) n_err++;
            chk("strobe_exclusive", msum, 1);
            if (q_kind.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got kind %0d expected none (cycle %0d)", mk, cyc);
            end else begin
                chk("strobe_kind", mk, q_kind.pop_front());
                chk("strobe_cycle", cyc, q_cyc.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int u0, d0, e0;
        // reset with both channels high: no power-up err
        repeat (3) @(posedge clk);
        #1;
        chk("rst_up", int'(Up), 0);
        chk("rst_dw", int'(Dw), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_dir", int'(dir), 0);
        chk("rst_errcnt", int'(err_cnt), 0);
        rst = 1'b0;
        m_p = 2'b11;
        repeat (30) @(posedge clk);
        #1;
        chk("post_rst_errcnt", int'(err_cnt), 0);
        chk("post_rst_nerr", n_err, 0);
        chk("post_rst_nup", n_up + n_dw, 0);

        // forward
        step(2'b01, 20);
        step(2'b00, 20);
        u0 = n_up; d0 = n_dw;
        step(2'b10, 20);
        step(2'b11, 20);
        step(2'b01, 20);
        step(2'b00, 20);
        #1;
        chk("fwd_up_count", n_up - u0, X4 ? 4 : 1);
        chk("fwd_dw_count", n_dw - d0, 0);
        chk("fwd_dir", int'(dir), 1);

        // backward, 3 cycles
        u0 = n_up; d0 = n_dw;
        for (int c = 0; c < 3; c++) begin
            step(2'b01, 20);
            step(2'b11, 20);
            step(2'b10, 20);
            step(2'b00, 20);
        end
        #1;
        chk("bwd_dw_count", n_dw - d0, X4 ? 12 : 3);
        chk("bwd_up_count", n_up - u0, 0);
        chk("bwd_dir", int'(dir), 0);

        // 5-cycle glitch on qa is dropped
        u0 = n_up; d0 = n_dw; e0 = n_err;
        @(posedge clk); #1; qa = 1'b1;
        repeat (5) @(posedge clk);
        #1; qa = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        chk("glitch5_strobes", (n_up - u0) + (n_dw - d0) + (n_err - e0), 0);

        // 9-cycle pulse is accepted both ways
        u0 = n_up; d0 = n_dw;
        step(2'b10, 9);
        step(2'b00, 25);
        #1;
        chk("glitch9_strobes", (n_up - u0) + (n_dw - d0), X4 ? 2 : 1);

        // illegal double step with dir = 1
        step(2'b10, 20);
        step(2'b11, 20);
        step(2'b01, 20);
        step(2'b00, 20);
        u0 = n_up; d0 = n_dw; e0 = n_err;
        step(2'b11, 20);
        #1;
        chk("illegal_nerr", n_err - e0, 1);
        chk("illegal_errcnt", int'(err_cnt), 1);
        chk("illegal_updw", (n_up - u0) + (n_dw - d0), 0);
        chk("illegal_dir", int'(dir), 1);

        // saturation: 300 more errors
        for (int i = 0; i < 300; i++)
            step((i % 2 == 0) ? 2'b00 : 2'b11, 12);
        repeat (5) @(posedge clk);
        #1;
        chk("sat_errcnt", int'(err_cnt), 255);

        // async reset while qa change is in the filter
        @(posedge clk); #1; qa = 1'b0;
        repeat (5) @(posedge clk);
        #3; rst = 1'b1;
        #1;
        chk("arst_errcnt", int'(err_cnt), 0);
        chk("arst_dir", int'(dir), 0);
        chk("arst_strobes", int'(Up) + int'(Dw) + int'(err), 0);
        repeat (3) @(posedge clk);
        #1; rst = 1'b0;
        m_p = 2'b01;
        u0 = n_up; d0 = n_dw; e0 = n_err;
        repeat (40) @(posedge clk);
        #1;
        chk("arst_no_strobe", (n_up - u0) + (n_dw - d0) + (n_err - e0), 0);

        // clr_err coinciding with err
        step(2'b10, 20);
        step(2'b01, 20);
        #1;
        chk("pre_clr_errcnt", int'(err_cnt), 2);
        @(posedge clk); #1;
        {qa, qb} = 2'b10;
        q_kind.push_back(3);
        q_cyc.push_back(cyc + LAT);
        m_p = 2'b10;
        repeat (LAT) @(posedge clk);
        #1;
        chk("clr_err_visible", int'(err), 1);
        clr_err = 1'b1;
        @(posedge clk); #1;
        clr_err = 1'b0;
        chk("clr_errcnt", int'(err_cnt), 0);
        repeat (5) @(posedge clk);
        #1;
        chk("clr_errcnt_hold", int'(err_cnt), 0);

        repeat (20) @(posedge clk);
        chk("missing_strobes", q_kind.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
